// File: rtl/nibble_serial_subtractor_pkg.sv
// Shared definitions for the nibble-serial subtractor: nibble width, FSM states
// and the nibble-count helper.
package nibble_serial_subtractor_pkg;

    localparam int unsigned NIB_W = 4;

    typedef enum logic {IDLE, RUN} state_e;

    function automatic int unsigned nibbles(int unsigned width);
        return width / NIB_W;
    endfunction

endpackage

// File: rtl/nibble_sub.sv
// Combinational 4-bit subtract slice: d = x - y - bi (mod 16), bo = 1 iff x < y + bi.
module nibble_sub
    import nibble_serial_subtractor_pkg::*;
(
    input  logic [NIB_W-1:0] x,
    input  logic [NIB_W-1:0] y,
    input  logic             bi,
    output logic [NIB_W-1:0] d,
    output logic             bo
);

    logic [NIB_W:0] t;

    // One extra bit catches the wrap; it is set exactly when the result went negative.
    always_comb begin
        t  = {1'b0, x} - {1'b0, y} - {{NIB_W{1'b0}}, bi};
        d  = t[NIB_W-1:0];
        bo = t[NIB_W];
    end

endmodule

// File: rtl/nibble_serial_subtractor.sv
// Multi-cycle WIDTH-bit subtractor, one nibble per clock, LSB first, start/done handshake.
// Optional signed-overflow output enabled by defining SUB_OVF_EN.
module nibble_serial_subtractor
    import nibble_serial_subtractor_pkg::*;
#(
    parameter int unsigned WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             bin,
    output logic             busy,
    output logic             done,
    output logic [WIDTH-1:0] diff,
    output logic             bout
`ifdef SUB_OVF_EN
    ,
    output logic             ovf
`endif
);

    localparam int unsigned NIBS  = nibbles(WIDTH);
    localparam int unsigned IDX_W = (NIBS > 1) ? $clog2(NIBS) : 1;
    localparam logic [IDX_W-1:0] LAST = IDX_W'(NIBS - 1);

    state_e             state_q, state_d;
    logic [IDX_W-1:0]   idx_q;
    logic [WIDTH-1:0]   a_q, b_q, res_q, res_d;
    logic               borrow_q;
    logic [WIDTH-1:0]   diff_q;
    logic               bout_q, done_q;
    logic [NIB_W-1:0]   nib_x, nib_y, nib_d;
    logic               nib_bo;
    logic               accept, last;

    assign accept = (state_q == IDLE) && start;
    assign last   = (state_q == RUN) && (idx_q == LAST);
    assign nib_x  = a_q[idx_q*NIB_W +: NIB_W];
    assign nib_y  = b_q[idx_q*NIB_W +: NIB_W];

    nibble_sub u_nibble_sub (
        .x  (nib_x),
        .y  (nib_y),
        .bi (borrow_q),
        .d  (nib_d),
        .bo (nib_bo)
    );

    // Working result with the current nibble merged in; loaded into diff on the last nibble.
    always_comb begin
        res_d = res_q;
        res_d[idx_q*NIB_W +: NIB_W] = nib_d;
    end

    always_ff @(posedge clk) begin
        if (rst) state_q <= IDLE;
        else     state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            IDLE: if (start) state_d = RUN;
            RUN:  if (idx_q == LAST) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_comb begin
        busy = (state_q == RUN);
        done = done_q;
        diff = diff_q;
        bout = bout_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q    <= '0;
            a_q      <= '0;
            b_q      <= '0;
            res_q    <= '0;
            borrow_q <= 1'b0;
            diff_q   <= '0;
            bout_q   <= 1'b0;
            done_q   <= 1'b0;
        end else begin
            done_q <= 1'b0;
            if (accept) begin
                a_q      <= a;
                b_q      <= b;
                borrow_q <= bin;
                res_q    <= '0;
                idx_q    <= '0;
            end else if (state_q == RUN) begin
                res_q    <= res_d;
                borrow_q <= nib_bo;
                idx_q    <= last ? '0 : idx_q + 1'b1;
                if (last) begin
                    diff_q <= res_d;
                    bout_q <= nib_bo;
                    done_q <= 1'b1;
                end
            end
        end
    end

`ifdef SUB_OVF_EN
    logic ovf_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            ovf_q <= 1'b0;
        end else if (last) begin
            ovf_q <= (a_q[WIDTH-1] != b_q[WIDTH-1]) && (res_d[WIDTH-1] != a_q[WIDTH-1]);
        end
    end

    assign ovf = ovf_q;
`endif

endmodule

// File: tb/tb_nibble_serial_subtractor.sv
// Directed, table-driven bench for nibble_serial_subtractor at WIDTH = 16.
// Signed-overflow checks are included when SUB_OVF_EN is defined.
module tb_nibble_serial_subtractor;

    logic        clk = 1'b0;
    logic        rst;
    logic        start;
    logic [15:0] a, b;
    logic        bin;
    logic        busy, done, bout;
    logic [15:0] diff;
`ifdef SUB_OVF_EN
    logic        ovf;
`endif

    int pass_cnt  = 0;
    int total_cnt = 0;

    logic [15:0] last_diff;
    logic        last_bout;

    always #5 clk = ~clk;

    nibble_serial_subtractor #(.WIDTH(16)) dut (
        .clk   (clk),
        .rst   (rst),
        .start (start),
        .a     (a),
        .b     (b),
        .bin   (bin),
        .busy  (busy),
        .done  (done),
        .diff  (diff),
        .bout  (bout)
`ifdef SUB_OVF_EN
        ,
        .ovf   (ovf)
`endif
    );

    typedef struct {
        logic [15:0] a;
        logic [15:0] b;
        logic        bin;
        logic [15:0] diff;
        logic        bout;
        logic        ovf;
    } vec_t;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total_cnt++;
        if (act === exp) pass_cnt++;
        else $display("FAIL %s: got %0h, want %0h", name, act, exp);
    endtask

    // Launch one subtraction and check latency, hold behaviour, result and done width.
    task automatic run_op(input logic [15:0] va, input logic [15:0] vb, input logic vbin,
                          input logic [15:0] ed, input logic eb, input logic eo,
                          input string tag);
        int lat;
        @(negedge clk);
        a = va; b = vb; bin = vbin; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        chk({tag, " busy after accept"}, 32'(busy), 32'd1);
        lat = 0;
        do begin
            if (!done) chk({tag, " diff held"}, 32'(diff), 32'(last_diff));
            @(posedge clk);
            @(negedge clk);
            lat++;
        end while (!done && lat < 10);
        chk({tag, " latency"}, 32'(lat), 32'd4);
        chk({tag, " diff"}, 32'(diff), 32'(ed));
        chk({tag, " bout"}, 32'(bout), 32'(eb));
        chk({tag, " busy at done"}, 32'(busy), 32'd0);
`ifdef SUB_OVF_EN
        chk({tag, " ovf"}, 32'(ovf), 32'(eo));
`else
        if (eo === 1'bx) $display("unexpected X in ovf vector for %s", tag);
`endif
        last_diff = ed;
        last_bout = eb;
        @(negedge clk);
        chk({tag, " done one cycle"}, 32'(done), 32'd0);
    endtask

    vec_t vecs [10];
    int   ndone;
    logic [15:0] done_diff;

    initial begin
        vecs[0] = '{16'h0007, 16'h0007, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[1] = '{16'h0007, 16'h0007, 1'b1, 16'hFFFF, 1'b1, 1'b0};
        vecs[2] = '{16'h1000, 16'h0001, 1'b0, 16'h0FFF, 1'b0, 1'b0};
        vecs[3] = '{16'h8000, 16'h0001, 1'b0, 16'h7FFF, 1'b0, 1'b1};
        vecs[4] = '{16'h0005, 16'h0003, 1'b0, 16'h0002, 1'b0, 1'b0};
        vecs[5] = '{16'h0000, 16'h0001, 1'b0, 16'hFFFF, 1'b1, 1'b0};
        vecs[6] = '{16'hFFFF, 16'hFFFF, 1'b0, 16'h0000, 1'b0, 1'b0};
        vecs[7] = '{16'hABCD, 16'h1234, 1'b1, 16'h9998, 1'b0, 1'b0};
        vecs[8] = '{16'h7FFF, 16'hFFFF, 1'b0, 16'h8000, 1'b1, 1'b1};
        vecs[9] = '{16'h1234, 16'h0235, 1'b0, 16'h0FFF, 1'b0, 1'b0};

        rst = 1'b1; start = 1'b0; a = '0; b = '0; bin = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("reset busy", 32'(busy), 32'd0);
        chk("reset done", 32'(done), 32'd0);
        chk("reset diff", 32'(diff), 32'd0);
        chk("reset bout", 32'(bout), 32'd0);
`ifdef SUB_OVF_EN
        chk("reset ovf", 32'(ovf), 32'd0);
`endif
        last_diff = 16'h0000;
        last_bout = 1'b0;

        for (int i = 0; i < 10; i++) begin
            run_op(vecs[i].a, vecs[i].b, vecs[i].bin, vecs[i].diff, vecs[i].bout,
                   vecs[i].ovf, $sformatf("vec%0d", i));
        end

        // Start while busy: a second request at edge 2 must be dropped.
        @(negedge clk);
        a = 16'h0010; b = 16'h0001; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        a = 16'hFFFF; b = 16'h0000; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        ndone = 0;
        done_diff = 16'h0000;
        for (int c = 0; c < 12; c++) begin
            if (done) begin
                ndone++;
                done_diff = diff;
            end
            @(posedge clk);
            @(negedge clk);
        end
        chk("busy-start done count", 32'(ndone), 32'd1);
        chk("busy-start diff", 32'(done_diff), 32'h000F);
        chk("busy-start final diff", 32'(diff), 32'h000F);
        chk("busy-start bout", 32'(bout), 32'd0);
        chk("busy-start idle", 32'(busy), 32'd0);

        // Reset at edge 2 of a run aborts it and clears outputs.
        @(negedge clk);
        a = 16'h1234; b = 16'h0001; bin = 1'b0; start = 1'b1;
        @(posedge clk);
        @(negedge clk);
        start = 1'b0;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b1;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        chk("midreset busy", 32'(busy), 32'd0);
        chk("midreset diff", 32'(diff), 32'd0);
        chk("midreset bout", 32'(bout), 32'd0);
`ifdef SUB_OVF_EN
        chk("midreset ovf", 32'(ovf), 32'd0);
`endif
        ndone = 0;
        for (int c = 0; c < 8; c++) begin
            if (done) ndone++;
            @(posedge clk);
            @(negedge clk);
        end
        chk("midreset no done", 32'(ndone), 32'd0);
        last_diff = 16'h0000;
        last_bout = 1'b0;
        run_op(16'h00FF, 16'h000F, 1'b0, 16'h00F0, 1'b0, 1'b0, "after reset");

        // rst and start together: rst wins, the request is dropped.
        @(negedge clk);
        rst = 1'b1; start = 1'b1; a = 16'h0001; b = 16'h0000;
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0; start = 1'b0;
        chk("rst+start busy", 32'(busy), 32'd0);
        ndone = 0;
        for (int c = 0; c < 8; c++) begin
            if (done) ndone++;
            @(posedge clk);
            @(negedge clk);
        end
        chk("rst+start no done", 32'(ndone), 32'd0);
        chk("rst+start diff", 32'(diff), 32'd0);

        $display("%0d/%0d checks passed", pass_cnt, total_cnt);
        $finish;
    end

endmodule

// File: doc/nibble_serial_subtractor.md
# nibble_serial_subtractor

Multi-cycle subtractor computing `diff = a - b - bin` on WIDTH-bit unsigned operands, one 4-bit nibble per clock, LSB nibble first, with a borrow chained between cycles. It is the inverse-direction counterpart of the 4-bit adder slice: it reuses the same nibble-width datapath idea, but sequences it over wide words behind a start/done handshake. It sits between the operand registers and the result bus, so wide subtraction costs one small slice rather than a full-width ripple chain.

## Interface
- WIDTH, 16, operand/result width; must be a multiple of 4 and ≥ 4; NIBBLES = WIDTH/4
- clk  in  1  rising-edge clock
- rst  in  1  synchronous, active-high reset
- start  in  1  request; sampled only when busy = 0
- a  in  WIDTH  minuend; captured on an accepted start
- b  in  WIDTH  subtrahend; captured on an accepted start
- bin  in  1  borrow-in; captured on an accepted start
- busy  out  1  high while a subtraction is in progress
- done  out  1  single-cycle completion pulse
- diff  out  WIDTH  result; held until the next completion
- bout  out  1  borrow-out; 1 iff a < b + bin (unsigned)
- ovf  out  1  signed overflow; present only with SUB_OVF_EN

## Operation
- States:
  - IDLE: waiting for start.
  - RUN: processing one nibble per cycle.
- IDLE → RUN on `start & ~busy`:
  - latch a, b and bin into working registers;
  - set nibble index = 0;
  - set running borrow = bin.
- In RUN, each cycle:
  - nibble i of the working result = a[i] - b[i] - borrow (mod 16);
  - borrow = 1 if a[i] < b[i] + borrow;
  - increment i.
- RUN → IDLE after nibble NIBBLES-1. On that same edge:
  - diff and bout are loaded from the working registers plus the final nibble and borrow;
  - done is set for one cycle.
- start is ignored while busy = 1. No queuing; the operands of an ignored request are discarded.
- diff and bout change only at completion. They are never partially updated.
- Arithmetic is modulo 2^WIDTH. `bin = 1` with `a == b` gives diff = all ones and bout = 1.
- Reset values: busy = 0, done = 0, diff = 0, bout = 0, ovf = 0, state = IDLE.
- Reset mid-RUN aborts the operation:
  - no done pulse;
  - diff, bout and ovf are cleared to 0.
- If rst and start are high together, rst wins and start is dropped.

## Timing
- Start is accepted at edge 0. Nibbles are computed at edges 1..NIBBLES.
- busy is high after edge 0 and low after edge NIBBLES.
- done is high for exactly the one cycle following edge NIBBLES; diff and bout are valid from that cycle onward.
- Latency = NIBBLES cycles from the accepting edge to valid result (4 cycles at WIDTH = 16).
- A start held high during the done cycle is accepted at the next edge (busy = 0 in that cycle). Back-to-back throughput is one result per NIBBLES+1 cycles.
- When WIDTH = 4, busy is high for exactly one cycle.

## Configuration
- SUB_OVF_EN defined:
  - the ovf port exists;
  - ovf = (a[MSB] != b[MSB]) & (diff[MSB] != a[MSB]), using the captured operands;
  - ovf is registered and updated with diff at completion.
- SUB_OVF_EN undefined:
  - the ovf port and its logic are absent;
  - all other behaviour is identical.

## Structure
- Shared package holds:
  - nibble width constant NIB_W = 4;
  - state enum {IDLE, RUN};
  - function NIBBLES(WIDTH).
- One combinational sub-module, nibble_sub: inputs x[3:0], y[3:0], bi; outputs d[3:0], bo. It is instantiated once and muxed by nibble index.
- Top level contains:
  - FSM;
  - nibble index counter, $clog2(NIBBLES) bits, minimum 1;
  - working registers;
  - output registers.

## Test plan
All scenarios use WIDTH = 16.
- Equal operands, no borrow: a = 0x0007, b = 0x0007, bin = 0 → after 4 cycles diff = 0x0000, bout = 0, done pulse exactly 1 cycle.
- Equal operands, borrow in: a = 0x0007, b = 0x0007, bin = 1 → diff = 0xFFFF, bout = 1.
- Borrow ripple: a = 0x1000, b = 0x0001, bin = 0 → diff = 0x0FFF, bout = 0.
- Signed overflow (SUB_OVF_EN): a = 0x8000, b = 0x0001 → diff = 0x7FFF, ovf = 1, bout = 0. Then a = 0x0005, b = 0x0003 → diff = 0x0002, ovf = 0.
- Start while busy:
  - pulse start at edge 2 with a = 0xFFFF, b = 0 during a run of 0x0010 - 0x0001;
  - required: first result 0x000F, second request ignored, only one done pulse.
- Reset mid-run: assert rst at edge 2 → busy = 0, diff = 0, bout = 0, no done. A new start then completes normally: 0x00FF - 0x000F → 0x00F0.
